// File: rtl/pe_pkg.sv
// Shared definitions for the PE multiply-accumulate slice: operand mode
// encoding and the saturating-add helper used by the accumulator stage.
package pe_pkg;

    localparam logic PE_MODE_UNSIGNED = 1'b0;
    localparam logic PE_MODE_SIGNED   = 1'b1;

    // Wide enough to hold any accumulator sum up to 64 bits without overflow.
    localparam int PE_CALC_W = 66;

    typedef logic signed [PE_CALC_W-1:0] pe_calc_t;

    typedef struct packed {
        logic     clamped;
        pe_calc_t value;
    } pe_sat_t;

    function automatic pe_sat_t pe_saturate(input pe_calc_t value, input logic mode, input int width);
        pe_calc_t hi;
        pe_calc_t lo;
        pe_sat_t  res;
        if (mode == PE_MODE_SIGNED) begin
            hi = (pe_calc_t'(1) <<< (width - 1)) - pe_calc_t'(1);
            lo = -(pe_calc_t'(1) <<< (width - 1));
        end else begin
            hi = (pe_calc_t'(1) <<< width) - pe_calc_t'(1);
            lo = '0;
        end
        res.clamped = 1'b0;
        res.value   = value;
        if (value > hi) begin
            res.clamped = 1'b1;
            res.value   = hi;
        end else if (value < lo) begin
            res.clamped = 1'b1;
            res.value   = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_mult_stage.sv
// Two-stage registered multiplier: S1 captures operands and beat tags, S2 holds
// the full-precision product already extended to accumulator width plus one.
module pe_mult_stage
    import pe_pkg::*;
#(
    parameter int A_W   = 8,
    parameter int B_W   = 4,
    parameter int ACC_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             hold_i,
    input  logic             valid_i,
    input  logic [A_W-1:0]   a_i,
    input  logic [B_W-1:0]   b_i,
    input  logic             mode_i,
    input  logic             last_i,
    output logic             valid_o,
    output logic             mode_o,
    output logic             last_o,
    output logic [ACC_W:0]   prod_o
);

    localparam int P_W = A_W + B_W;

    logic             s1_valid_q;
    logic [A_W-1:0]   s1_a_q;
    logic [B_W-1:0]   s1_b_q;
    logic             s1_mode_q;
    logic             s1_last_q;
    logic             s2_valid_q;
    logic             s2_mode_q;
    logic             s2_last_q;
    logic [ACC_W:0]   s2_prod_q;

    logic             s1_signed;
    logic [P_W-1:0]   a_ext;
    logic [P_W-1:0]   b_ext;
    logic [P_W-1:0]   prod_full;
    logic [ACC_W:0]   prod_d;

    // Extending both operands to P_W makes one P_W-bit multiply exact for both modes.
    always_comb begin
        s1_signed = (s1_mode_q == PE_MODE_SIGNED);
        a_ext     = {{B_W{s1_a_q[A_W-1] & s1_signed}}, s1_a_q};
        b_ext     = {{A_W{s1_b_q[B_W-1] & s1_signed}}, s1_b_q};
        prod_full = a_ext * b_ext;
        prod_d    = {{(ACC_W + 1 - P_W){prod_full[P_W-1] & s1_signed}}, prod_full};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_mode_q  <= PE_MODE_UNSIGNED;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_mode_q  <= PE_MODE_UNSIGNED;
            s2_last_q  <= 1'b0;
            s2_prod_q  <= '0;
        end else if (!hold_i) begin
            s1_valid_q <= valid_i;
            s1_a_q     <= a_i;
            s1_b_q     <= b_i;
            s1_mode_q  <= mode_i;
            s1_last_q  <= last_i;
            s2_valid_q <= s1_valid_q;
            s2_mode_q  <= s1_mode_q;
            s2_last_q  <= s1_last_q;
            s2_prod_q  <= prod_d;
        end
    end

    assign valid_o = s2_valid_q;
    assign mode_o  = s2_mode_q;
    assign last_o  = s2_last_q;
    assign prod_o  = s2_prod_q;

endmodule

// File: rtl/pe_mac_acc.sv
// Pipelined saturating multiply-accumulate PE: groups of len beats are summed
// and emitted as one result through a valid/ready output register.
module pe_mac_acc
    import pe_pkg::*;
#(
    parameter int A_W   = 8,
    parameter int B_W   = 4,
    parameter int ACC_W = 16,
    parameter int K_MAX = 16,
    parameter int CNT_W = $clog2(K_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             signed_mode,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_sat
);

    logic             stall;
    logic             advance;
    logic             accept;
    logic             first_beat;
    logic [CNT_W-1:0] len_clamped;
    logic [CNT_W-1:0] beat_len;
    logic             beat_mode;
    logic             beat_last;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] grp_len_q, grp_len_d;
    logic             grp_mode_q, grp_mode_d;

    logic             s2_valid;
    logic             s2_mode;
    logic             s2_last;
    logic [ACC_W:0]   s2_prod;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             flag_q, flag_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_sat_q, out_sat_d;

    pe_calc_t         acc_ext;
    pe_calc_t         prod_ext;
    pe_sat_t          sat_r;
    logic [ACC_W-1:0] acc_next;

    assign stall    = out_valid_q && !out_ready;
    assign advance  = en && !stall;
    assign in_ready = rst_n && advance;
    assign accept   = in_valid && in_ready;

    // Group config is latched from the first beat so mid-group input changes are ignored.
    always_comb begin
        first_beat  = (cnt_q == '0);
        len_clamped = len;
        if (len == '0) begin
            len_clamped = CNT_W'(1);
        end else if (len > CNT_W'(K_MAX)) begin
            len_clamped = CNT_W'(K_MAX);
        end
        beat_len   = first_beat ? len_clamped : grp_len_q;
        beat_mode  = first_beat ? signed_mode : grp_mode_q;
        beat_last  = (cnt_q == beat_len - CNT_W'(1));
        cnt_d      = cnt_q;
        grp_len_d  = grp_len_q;
        grp_mode_d = grp_mode_q;
        if (accept) begin
            cnt_d = beat_last ? '0 : cnt_q + CNT_W'(1);
            if (first_beat) begin
                grp_len_d  = beat_len;
                grp_mode_d = beat_mode;
            end
        end
    end

    pe_mult_stage #(
        .A_W   (A_W),
        .B_W   (B_W),
        .ACC_W (ACC_W)
    ) u_mult (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .hold_i  (!advance),
        .valid_i (accept),
        .a_i     (a),
        .b_i     (b),
        .mode_i  (beat_mode),
        .last_i  (beat_last),
        .valid_o (s2_valid),
        .mode_o  (s2_mode),
        .last_o  (s2_last),
        .prod_o  (s2_prod)
    );

    always_comb begin
        acc_ext     = {{(PE_CALC_W - ACC_W){acc_q[ACC_W-1] & (s2_mode == PE_MODE_SIGNED)}}, acc_q};
        prod_ext    = {{(PE_CALC_W - ACC_W - 1){s2_prod[ACC_W]}}, s2_prod};
        sat_r       = pe_saturate(acc_ext + prod_ext, s2_mode, ACC_W);
        acc_next    = ACC_W'(sat_r.value);
        acc_d       = acc_q;
        flag_d      = flag_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_sat_d   = out_sat_q;
        if (advance) begin
            if (s2_valid && s2_last) begin
                acc_d       = '0;
                flag_d      = 1'b0;
                out_valid_d = 1'b1;
                out_sum_d   = acc_next;
                out_sat_d   = flag_q | sat_r.clamped;
            end else begin
                if (s2_valid) begin
                    acc_d  = acc_next;
                    flag_d = flag_q | sat_r.clamped;
                end
                if (out_valid_q) begin
                    out_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            grp_len_q   <= CNT_W'(1);
            grp_mode_q  <= PE_MODE_UNSIGNED;
            acc_q       <= '0;
            flag_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            grp_len_q   <= grp_len_d;
            grp_mode_q  <= grp_mode_d;
            acc_q       <= acc_d;
            flag_q      <= flag_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_pe_mac_acc.sv
// Bench for pe_mac_acc: a 16-bit and a 12-bit accumulator instance share the
// same stimulus and are checked against a group-level arithmetic model.
module tb_pe_mac_acc;

    localparam int A_W   = 8;
    localparam int B_W   = 4;
    localparam int K_MAX = 16;
    localparam int CNT_W = $clog2(K_MAX + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             signed_mode;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic [A_W-1:0]   a;
    logic [B_W-1:0]   b;
    logic             out_ready;

    logic             in_ready16, out_valid16, out_sat16;
    logic [15:0]      out_sum16;
    logic             in_ready12, out_valid12, out_sat12;
    logic [11:0]      out_sum12;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int gotSum16[$], gotSat16[$], gotCyc16[$];
    int gotSum12[$], gotSat12[$];
    int expSum16[$], expSat16[$];
    int expSum12[$], expSat12[$];

    logic [A_W-1:0] grpA[$];
    logic [B_W-1:0] grpB[$];
    bit             grpMode;
    int             grpLen;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pe_mac_acc #(.A_W(A_W), .B_W(B_W), .ACC_W(16), .K_MAX(K_MAX)) dut16 (
        .clk(clk), .rst_n(rst_n), .en(en), .signed_mode(signed_mode), .len(len),
        .in_valid(in_valid), .in_ready(in_ready16), .a(a), .b(b),
        .out_valid(out_valid16), .out_ready(out_ready), .out_sum(out_sum16), .out_sat(out_sat16)
    );

    pe_mac_acc #(.A_W(A_W), .B_W(B_W), .ACC_W(12), .K_MAX(K_MAX)) dut12 (
        .clk(clk), .rst_n(rst_n), .en(en), .signed_mode(signed_mode), .len(len),
        .in_valid(in_valid), .in_ready(in_ready12), .a(a), .b(b),
        .out_valid(out_valid12), .out_ready(out_ready), .out_sum(out_sum12), .out_sat(out_sat12)
    );

    // Results are taken on the negedge before the edge that consumes them.
    always @(negedge clk) begin
        if (rst_n && en && out_ready) begin
            if (out_valid16) begin
                gotSum16.push_back(int'(out_sum16));
                gotSat16.push_back(int'(out_sat16));
                gotCyc16.push_back(cyc);
            end
            if (out_valid12) begin
                gotSum12.push_back(int'(out_sum12));
                gotSat12.push_back(int'(out_sat12));
            end
        end
    end

    function automatic longint prodOf(input logic [A_W-1:0] av, input logic [B_W-1:0] bv, input bit sm);
        if (sm) return longint'($signed(av)) * longint'($signed(bv));
        return longint'(av) * longint'(bv);
    endfunction

    function automatic longint groupSum(input int w, output bit sat);
        longint acc, lo, hi;
        acc = 0;
        sat = 0;
        if (grpMode) begin
            lo = -(longint'(1) << (w - 1));
            hi = (longint'(1) << (w - 1)) - 1;
        end else begin
            lo = 0;
            hi = (longint'(1) << w) - 1;
        end
        foreach (grpA[i]) begin
            acc = acc + prodOf(grpA[i], grpB[i], grpMode);
            if (acc > hi) begin acc = hi; sat = 1; end
            else if (acc < lo) begin acc = lo; sat = 1; end
        end
        return acc & ((longint'(1) << w) - 1);
    endfunction

    function automatic void modelBeat(input logic [A_W-1:0] av, input logic [B_W-1:0] bv, input bit sm, input int ln);
        longint s;
        bit sat;
        if (grpA.size() == 0) begin
            grpMode = sm;
            grpLen  = (ln == 0) ? 1 : (ln > K_MAX) ? K_MAX : ln;
        end
        grpA.push_back(av);
        grpB.push_back(bv);
        if (grpA.size() == grpLen) begin
            s = groupSum(16, sat);
            expSum16.push_back(int'(s));
            expSat16.push_back(int'(sat));
            s = groupSum(12, sat);
            expSum12.push_back(int'(s));
            expSat12.push_back(int'(sat));
            grpA.delete();
            grpB.delete();
        end
    endfunction

    task automatic clearState();
        gotSum16.delete(); gotSat16.delete(); gotCyc16.delete();
        gotSum12.delete(); gotSat12.delete();
        expSum16.delete(); expSat16.delete(); expSum12.delete(); expSat12.delete();
        grpA.delete(); grpB.delete();
    endtask

    // Drives one beat and retries (releasing backpressure) until it is accepted.
    task automatic applyStimulus(input logic [A_W-1:0] av, input logic [B_W-1:0] bv, input bit sm,
                                 input int ln, output int accCyc, output int waits);
        bit ok;
        ok = 0;
        waits = 0;
        accCyc = -1;
        a = av; b = bv; signed_mode = sm; len = CNT_W'(ln); in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready16;
            @(posedge clk);
            #1;
            if (!ok) begin waits++; out_ready = 1'b1; end
        end
        in_valid = 1'b0;
        if (ok) begin
            accCyc = cyc;
            modelBeat(av, bv, sm, ln);
        end else begin
            total++; bad++;
            $display("[TB] FAIL accept: in_ready got 0 for 50 cycles, want 1");
        end
    endtask

    task automatic waitResults(output bit ok);
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (gotSum16.size() >= expSum16.size() && gotSum12.size() >= expSum12.size()) ok = 1;
            else begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset();
        total++;
        if ({in_ready16, out_valid16, out_sat16, out_sum16} !== 19'd0) begin
            bad++;
            $display("[TB] FAIL reset16: got rdy=%b vld=%b sat=%b sum=%h, want all 0", in_ready16, out_valid16, out_sat16, out_sum16);
        end
        total++;
        if ({in_ready12, out_valid12, out_sat12, out_sum12} !== 15'd0) begin
            bad++;
            $display("[TB] FAIL reset12: got rdy=%b vld=%b sat=%b sum=%h, want all 0", in_ready12, out_valid12, out_sat12, out_sum12);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        en = 1'b1; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready16 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ready_after_reset: got %b, want 1", in_ready16);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned_basic();
        int c, w, wsum, lastC;
        bit ok;
        clearState();
        wsum = 0;
        applyStimulus(8'd1, 4'd1, 1'b0, 3, c, w); wsum += w;
        applyStimulus(8'd2, 4'd2, 1'b0, 3, c, w); wsum += w;
        applyStimulus(8'd4, 4'd4, 1'b0, 3, lastC, w); wsum += w;
        waitResults(ok);
        total++;
        if (!ok || gotSum16.size() != 1) begin bad++; $display("[TB] FAIL basic_count: got %0d results, want 1", gotSum16.size()); end
        total++;
        if (wsum != 0) begin bad++; $display("[TB] FAIL basic_ready: got %0d stalled cycles, want 0", wsum); end
        total++;
        if (gotSum16[0] != 21 || gotSat16[0] != 0) begin
            bad++; $display("[TB] FAIL basic_sum: got sum=%0d sat=%0d, want sum=21 sat=0", gotSum16[0], gotSat16[0]);
        end
        total++;
        if (gotCyc16[0] != lastC + 2) begin bad++; $display("[TB] FAIL basic_latency: got edge %0d, want %0d", gotCyc16[0], lastC + 2); end
        total++;
        if (gotSum12[0] != expSum12[0]) begin bad++; $display("[TB] FAIL basic_sum12: got %0d, want %0d", gotSum12[0], expSum12[0]); end
        total++;
        if (out_valid16 !== 1'b0) begin bad++; $display("[TB] FAIL basic_consume: out_valid got %b, want 0", out_valid16); end
    endtask

    task automatic test_signed();
        int c, w;
        bit ok;
        clearState();
        applyStimulus(8'h80, 4'h7, 1'b1, 2, c, w);
        applyStimulus(8'h80, 4'h7, 1'b1, 2, c, w);
        applyStimulus(8'hFF, 4'h8, 1'b1, 1, c, w);
        waitResults(ok);
        total++;
        if (!ok || gotSum16.size() != 2) begin bad++; $display("[TB] FAIL signed_count: got %0d results, want 2", gotSum16.size()); end
        total++;
        if (gotSum16[0] != 'hF900 || gotSat16[0] != 0) begin
            bad++; $display("[TB] FAIL signed_dot: got sum=%h sat=%0d, want sum=f900 sat=0", gotSum16[0], gotSat16[0]);
        end
        total++;
        if (gotSum16[1] != 8) begin bad++; $display("[TB] FAIL signed_neg: got %0d, want 8", gotSum16[1]); end
        foreach (expSum12[i]) begin
            total++;
            if (gotSum12[i] != expSum12[i] || gotSat12[i] != expSat12[i]) begin
                bad++; $display("[TB] FAIL signed12[%0d]: got %h/%0d, want %h/%0d", i, gotSum12[i], gotSat12[i], expSum12[i], expSat12[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int c, w;
        bit ok;
        int want12[3] = '{'h800, 'hFFF, 1};
        int wantSat12[3] = '{1, 1, 0};
        clearState();
        repeat (3) applyStimulus(8'h80, 4'h7, 1'b1, 3, c, w);
        repeat (2) applyStimulus(8'd255, 4'd15, 1'b0, 2, c, w);
        applyStimulus(8'd1, 4'd1, 1'b0, 1, c, w);
        waitResults(ok);
        total++;
        if (!ok || gotSum12.size() != 3) begin bad++; $display("[TB] FAIL sat_count: got %0d results, want 3", gotSum12.size()); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (gotSum12[i] != want12[i] || gotSat12[i] != wantSat12[i]) begin
                bad++; $display("[TB] FAIL sat12[%0d]: got %h/%0d, want %h/%0d", i, gotSum12[i], gotSat12[i], want12[i], wantSat12[i]);
            end
            total++;
            if (gotSum16[i] != expSum16[i] || gotSat16[i] != expSat16[i]) begin
                bad++; $display("[TB] FAIL sat16[%0d]: got %h/%0d, want %h/%0d", i, gotSum16[i], gotSat16[i], expSum16[i], expSat16[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int c, w;
        bit ok;
        clearState();
        out_ready = 1'b0;
        applyStimulus(8'd6, 4'd7, 1'b0, 1, c, w);
        for (int i = 0; i < 10 && !out_valid16; i++) begin @(posedge clk); #1; end
        total++;
        if (out_valid16 !== 1'b1) begin bad++; $display("[TB] FAIL bp_arrive: out_valid got %b, want 1", out_valid16); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (in_ready16 !== 1'b0 || out_valid16 !== 1'b1 || out_sum16 !== 16'd42) begin
                bad++; $display("[TB] FAIL bp_hold[%0d]: got rdy=%b vld=%b sum=%0d, want 0/1/42", i, in_ready16, out_valid16, out_sum16);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
            bad++; $display("[TB] FAIL bp_release: got vld=%b rdy=%b, want 0/1", out_valid16, in_ready16);
        end
        applyStimulus(8'd3, 4'd5, 1'b0, 1, c, w);
        waitResults(ok);
        total++;
        if (!ok || gotSum16.size() != 2 || gotSum16[0] != 42 || gotSum16[1] != 15) begin
            bad++; $display("[TB] FAIL bp_results: got n=%0d %0d,%0d, want 2 42,15", gotSum16.size(), gotSum16[0], gotSum16[1]);
        end
        total++;
        if (gotCyc16[1] != c + 2) begin bad++; $display("[TB] FAIL bp_latency: got edge %0d, want %0d", gotCyc16[1], c + 2); end
    endtask

    task automatic test_len_zero();
        int c, w;
        bit ok;
        clearState();
        for (int i = 0; i < 3; i++)
            applyStimulus(A_W'($urandom), B_W'($urandom), 1'($urandom), 0, c, w);
        waitResults(ok);
        total++;
        if (!ok || gotSum16.size() != 3) begin bad++; $display("[TB] FAIL len0_count: got %0d results, want 3", gotSum16.size()); end
        foreach (expSum16[i]) begin
            total++;
            if (gotSum16[i] != expSum16[i] || gotSum12[i] != expSum12[i]) begin
                bad++; $display("[TB] FAIL len0[%0d]: got %h/%h, want %h/%h", i, gotSum16[i], gotSum12[i], expSum16[i], expSum12[i]);
            end
        end
    endtask

    task automatic test_enable_toggle();
        int c0, c1, c, w;
        bit ok;
        clearState();
        applyStimulus(8'd3, 4'd4, 1'b0, 3, c0, w);
        applyStimulus(8'd5, 4'd6, 1'b0, 3, c, w);
        applyStimulus(8'd7, 4'd8, 1'b0, 3, c, w);
        waitResults(ok);
        applyStimulus(8'd3, 4'd4, 1'b0, 3, c1, w);
        en = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        en = 1'b1;
        applyStimulus(8'd5, 4'd6, 1'b0, 3, c, w);
        applyStimulus(8'd7, 4'd8, 1'b0, 3, c, w);
        waitResults(ok);
        total++;
        if (!ok || gotSum16.size() != 2 || gotSum16[0] != 98 || gotSum16[1] != 98) begin
            bad++; $display("[TB] FAIL en_sum: got n=%0d %0d,%0d, want 2 98,98", gotSum16.size(), gotSum16[0], gotSum16[1]);
        end
        total++;
        if (gotCyc16[0] - c0 != 4 || gotCyc16[1] - c1 != 6) begin
            bad++; $display("[TB] FAIL en_latency: got %0d/%0d edges, want 4/6", gotCyc16[0] - c0, gotCyc16[1] - c1);
        end
    endtask

    task automatic test_random();
        int c, w;
        bit ok;
        clearState();
        for (int i = 0; i < 120 || grpA.size() != 0; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            applyStimulus(A_W'($urandom), B_W'($urandom), 1'($urandom), $urandom_range(0, 31), c, w);
        end
        out_ready = 1'b1;
        waitResults(ok);
        total++;
        if (!ok || gotSum16.size() != expSum16.size() || gotSum12.size() != expSum12.size()) begin
            bad++; $display("[TB] FAIL rand_count: got %0d/%0d, want %0d", gotSum16.size(), gotSum12.size(), expSum16.size());
        end
        foreach (expSum16[i]) begin
            total++;
            if (gotSum16[i] != expSum16[i] || gotSat16[i] != expSat16[i] ||
                gotSum12[i] != expSum12[i] || gotSat12[i] != expSat12[i]) begin
                bad++; $display("[TB] FAIL rand[%0d]: got %h/%0d %h/%0d, want %h/%0d %h/%0d", i,
                                gotSum16[i], gotSat16[i], gotSum12[i], gotSat12[i],
                                expSum16[i], expSat16[i], expSum12[i], expSat12[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int c, w;
        bit ok;
        clearState();
        out_ready = 1'b0;
        applyStimulus(8'd5, 4'd5, 1'b0, 1, c, w);
        applyStimulus(8'd9, 4'd9, 1'b0, 3, c, w);
        for (int i = 0; i < 10 && !out_valid16; i++) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid16, out_sat16, out_sum16, out_valid12, out_sum12, in_ready16} !== 31'd0) begin
            bad++; $display("[TB] FAIL rst_mid: got vld=%b sum=%h vld12=%b sum12=%h rdy=%b, want all 0",
                            out_valid16, out_sum16, out_valid12, out_sum12, in_ready16);
        end
        clearState();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        applyStimulus(8'd2, 4'd3, 1'b0, 2, c, w);
        applyStimulus(8'd1, 4'd1, 1'b0, 2, c, w);
        waitResults(ok);
        total++;
        if (!ok || gotSum16.size() != 1 || gotSum16[0] != 7 || gotSum12[0] != 7 || gotSat16[0] != 0) begin
            bad++; $display("[TB] FAIL rst_fresh: got n=%0d sum=%0d sum12=%0d, want 1 7 7", gotSum16.size(), gotSum16[0], gotSum12[0]);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; signed_mode = 1'b0; len = '0;
        in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
        #12;
        test_reset();
        test_unsigned_basic();
        test_signed();
        test_saturation();
        test_backpressure();
        test_len_zero();
        test_enable_toggle();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
